// File: rtl/matrix_bram_pkg.sv
// Shared types and constants for the matrix storage BRAM read-port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package matrix_bram_pkg;

  localparam int ADDR_WIDTH = 14;
  localparam int DATA_WIDTH = 32;
  localparam int BLOCK_SIZE = 1152;
  localparam int MAX_REQ    = 8;
  localparam int ID_WIDTH   = 3;   // enough to name any of MAX_REQ requesters

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } arb_state_t;

  localparam logic [ID_WIDTH-1:0] REQ_SCANNER = 3'd0;
  localparam logic [ID_WIDTH-1:0] REQ_FETCH   = 3'd1;
  localparam logic [ID_WIDTH-1:0] REQ_DISPLAY = 3'd2;
  localparam logic [ID_WIDTH-1:0] REQ_UART    = 3'd3;

endpackage

// File: rtl/matrix_bram_arbiter_rr_picker.sv
// Round-robin pick: first asserted req found scanning upward from ptr, wrapping at NUM_REQ.
// Latency: purely combinational.
// Backpressure: none; pick is all-zero when nothing requests.
module rr_picker
  import matrix_bram_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic [NUM_REQ-1:0]  pick,
  output logic [ID_WIDTH-1:0] pick_id
);

  int   idx;
  logic found;

  // Scan the request vector in rotated order and keep the first hit.
  always_comb begin
    pick    = '0;
    pick_id = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found         = 1'b1;
        pick[idx]     = 1'b1;
        pick_id       = idx[ID_WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/matrix_bram_arbiter.sv
// Shares the BRAM read port among NUM_REQ requesters (round-robin, optional burst lock).
// Latency: grant same cycle as req; rvalid/rdata READ_LATENCY cycles after the grant.
// Backpressure: a requester holds req/addr until gnt; non-owners stall while a lock is held.
module matrix_bram_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int ADDR_WIDTH   = 14,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rvalid,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          bram_en,
  output logic [ADDR_WIDTH-1:0]         bram_addr,
  input  logic [DATA_WIDTH-1:0]         bram_rdata,
  output logic                          owner_valid,
  output logic [2:0]                    owner_id
);

  import matrix_bram_pkg::*;

  localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(NUM_REQ - 1);

  arb_state_t            state_q, state_d;
  logic [ID_WIDTH-1:0]   owner_q, owner_d;
  logic [ID_WIDTH-1:0]   rr_ptr_q;
  logic [NUM_REQ-1:0]    pick;
  logic [ID_WIDTH-1:0]   pick_id;
  logic                  owner_hold;
  logic                  grant_any;
  logic [ID_WIDTH-1:0]   grant_id;
  logic [ADDR_WIDTH-1:0] addr_sel;
  logic [ADDR_WIDTH-1:0] addr_hold_q;
  logic [READ_LATENCY-1:0] pipe_vld_q;
  logic [ID_WIDTH-1:0]   pipe_id_q [READ_LATENCY];

  // While locked, rr_ptr already sits at owner+1, so the picker naturally
  // restarts there the cycle the owner lets go.
  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req     (req),
    .ptr     (rr_ptr_q),
    .pick    (pick),
    .pick_id (pick_id)
  );

  // Lock FSM next state and grant selection; grants are suppressed in reset.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    gnt        = '0;
    grant_any  = 1'b0;
    grant_id   = '0;
    owner_hold = (state_q == LOCKED) && req[owner_q] && lock[owner_q];
    if (!rst) begin
      if (owner_hold) begin
        gnt[owner_q] = 1'b1;
        grant_any    = 1'b1;
        grant_id     = owner_q;
      end else begin
        // Owner released (or never locked): arbitrate normally this cycle.
        state_d = UNLOCKED;
        owner_d = '0;
        if (|pick) begin
          gnt       = pick;
          grant_any = 1'b1;
          grant_id  = pick_id;
          if (lock[pick_id]) begin
            state_d = LOCKED;
            owner_d = pick_id;
          end
        end
      end
    end
  end

  // Lock state and owner registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= UNLOCKED;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  // Round-robin pointer advances past each non-locked-beat winner; frozen during a lock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else if (grant_any && !owner_hold) begin
      rr_ptr_q <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
    end
  end

  assign addr_sel  = addr[grant_id*ADDR_WIDTH +: ADDR_WIDTH];
  assign bram_en   = grant_any;
  assign bram_addr = grant_any ? addr_sel : addr_hold_q;

  // Remember the last issued address so bram_addr is steady while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_hold_q <= '0;
    end else if (grant_any) begin
      addr_hold_q <= addr_sel;
    end
  end

  // Return pipeline: carries {valid, id} alongside the BRAM read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld_q <= '0;
      for (int k = 0; k < READ_LATENCY; k++) pipe_id_q[k] <= '0;
    end else begin
      pipe_vld_q[0] <= grant_any;
      pipe_id_q[0]  <= grant_id;
      for (int k = 1; k < READ_LATENCY; k++) begin
        pipe_vld_q[k] <= pipe_vld_q[k-1];
        pipe_id_q[k]  <= pipe_id_q[k-1];
      end
    end
  end

  // Steer the returning BRAM word to the requester that issued it.
  always_comb begin
    rvalid = '0;
    rdata  = '0;
    if (pipe_vld_q[READ_LATENCY-1]) begin
      rvalid[pipe_id_q[READ_LATENCY-1]] = 1'b1;
      rdata                             = bram_rdata;
    end
  end

  assign owner_valid = (state_q == LOCKED);
  assign owner_id    = 3'(owner_q);

endmodule

// File: tb/tb_matrix_bram_arbiter.sv
// Directed bench: three arbiters (READ_LATENCY 1/2/3) share one stimulus stream.
// Latency: each instance has a behavioural BRAM model of matching depth.
// Backpressure: stimulus honours gnt by construction of the directed vectors.
module tb_matrix_bram_arbiter;

  localparam int N  = 4;
  localparam int AW = 14;
  localparam int DW = 32;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req;
  logic [N-1:0]    lock;
  logic [N*AW-1:0] addr;

  logic [N-1:0]  gnt1, rv1, gnt2, rv2, gnt3, rv3;
  logic [DW-1:0] rd1, rd2, rd3, brd1, brd2, brd3;
  logic          en1, en2, en3, ov1, ov2, ov3;
  logic [AW-1:0] ba1, ba2, ba3;
  logic [2:0]    oid1, oid2, oid3;
  logic [DW-1:0] m2a, m3a, m3b;

  int n_chk  = 0;
  int n_pass = 0;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return 32'hBEEF_0000 | {18'd0, a};
  endfunction

  matrix_bram_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .addr(addr),
    .gnt(gnt1), .rvalid(rv1), .rdata(rd1), .bram_en(en1), .bram_addr(ba1),
    .bram_rdata(brd1), .owner_valid(ov1), .owner_id(oid1));

  matrix_bram_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .addr(addr),
    .gnt(gnt2), .rvalid(rv2), .rdata(rd2), .bram_en(en2), .bram_addr(ba2),
    .bram_rdata(brd2), .owner_valid(ov2), .owner_id(oid2));

  matrix_bram_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .addr(addr),
    .gnt(gnt3), .rvalid(rv3), .rdata(rd3), .bram_en(en3), .bram_addr(ba3),
    .bram_rdata(brd3), .owner_valid(ov3), .owner_id(oid3));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // BRAM models: word depends only on address, delivered after 1/2/3 edges.
  always @(posedge clk) begin
    brd1 <= mem_word(ba1);
    m2a  <= mem_word(ba2);
    brd2 <= m2a;
    m3a  <= mem_word(ba3);
    m3b  <= m3a;
    brd3 <= m3b;
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    addr[i*AW +: AW] = a;
  endtask

  initial begin
    rst  = 1'b1;
    req  = 4'b1111;
    lock = 4'b0000;
    addr = '0;
    #2;
    // Reset state, with requests pending to show grants are forced off.
    check("rst_gnt",   32'(gnt1), 32'h0);
    check("rst_en",    32'(en1),  32'h0);
    check("rst_rv",    32'(rv1),  32'h0);
    check("rst_rdata", rd1,       32'h0);
    check("rst_baddr", 32'(ba1),  32'h0);
    check("rst_ov",    32'(ov1),  32'h0);
    check("rst_oid",   32'(oid1), 32'h0);

    // Single read from requester 0, latency 1.
    next_cycle();
    rst = 1'b0;
    req = 4'b0001;
    set_addr(0, 14'h0480);
    #1;
    check("single_gnt",   32'(gnt1), 32'h1);
    check("single_en",    32'(en1),  32'h1);
    check("single_baddr", 32'(ba1),  32'h0480);
    next_cycle();
    req = 4'b0000;
    #1;
    check("single_rv",    32'(rv1), 32'h1);
    check("single_rdata", rd1,      32'hBEEF_0480);
    check("idle_gnt",     32'(gnt1), 32'h0);
    check("idle_en",      32'(en1),  32'h0);
    check("idle_hold",    32'(ba1),  32'h0480);

    // Round-robin sweep; a grant to 3 first brings rr_ptr back to 0.
    for (int i = 0; i < N; i++) set_addr(i, 14'(14'h100 + i));
    next_cycle();
    req = 4'b1000;
    #1;
    check("rr_pre_gnt", 32'(gnt1), 32'h8);
    for (int k = 0; k < 8; k++) begin
      next_cycle();
      req = 4'b1111;
      #1;
      check("rr_gnt", 32'(gnt1), 32'(1 << (k % 4)));
      if (k == 0) begin
        check("rr_rv",    32'(rv1), 32'h8);
        check("rr_rdata", rd1,      32'hBEEF_0103);
      end else begin
        check("rr_rv",    32'(rv1), 32'(1 << ((k - 1) % 4)));
        check("rr_rdata", rd1,      32'hBEEF_0100 + 32'((k - 1) % 4));
      end
    end
    next_cycle();
    req = 4'b0000;
    #1;
    check("rr_last_rv",    32'(rv1), 32'h8);
    check("rr_last_rdata", rd1,      32'hBEEF_0103);
    check("rr_last_en",    32'(en1), 32'h0);

    // Lock by requester 2 for five beats while 0 and 1 keep requesting.
    set_addr(2, 14'h0222);
    next_cycle();
    req = 4'b0010;
    #1;
    check("lk_pre_gnt", 32'(gnt1), 32'h2);
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      req  = 4'b0111;
      lock = 4'b0100;
      #1;
      check("lk_gnt",   32'(gnt1), 32'h4);
      check("lk_baddr", 32'(ba1),  32'h0222);
      check("lk_ov",    32'(ov1),  (k > 0) ? 32'h1 : 32'h0);
      check("lk_oid",   32'(oid1), (k > 0) ? 32'h2 : 32'h0);
    end
    next_cycle();
    req  = 4'b0011;
    lock = 4'b0000;
    #1;
    check("lk_rel_gnt", 32'(gnt1), 32'h1);
    next_cycle();
    req = 4'b0000;
    #1;
    check("lk_rel_ov",  32'(ov1),  32'h0);
    check("lk_rel_oid", 32'(oid1), 32'h0);

    // Lock handoff: owner 1 drops lock while 3 requests with lock.
    next_cycle();
    req  = 4'b0010;
    lock = 4'b0010;
    #1;
    check("ho_gnt1", 32'(gnt1), 32'h2);
    next_cycle();
    req  = 4'b1010;
    lock = 4'b1010;
    #1;
    check("ho_gnt1b", 32'(gnt1), 32'h2);
    check("ho_ov1",   32'(ov1),  32'h1);
    check("ho_oid1",  32'(oid1), 32'h1);
    next_cycle();
    lock = 4'b1000;
    #1;
    check("ho_gnt3", 32'(gnt1), 32'h8);
    next_cycle();
    req  = 4'b0000;
    lock = 4'b0000;
    #1;
    check("ho_ov3",  32'(ov1),  32'h1);
    check("ho_oid3", 32'(oid1), 32'h3);
    check("ho_gnt0", 32'(gnt1), 32'h0);
    next_cycle();
    check("ho_unlock", 32'(ov1), 32'h0);
    for (int k = 0; k < 3; k++) next_cycle();

    // Latency 3: alternating grants 1,0,1.
    for (int c = 0; c < 7; c++) begin
      next_cycle();
      case (c)
        0: begin req = 4'b0010; set_addr(1, 14'h00A1); end
        1: begin req = 4'b0001; set_addr(0, 14'h00A2); end
        2: begin req = 4'b0010; set_addr(1, 14'h00A3); end
        default: req = 4'b0000;
      endcase
      #1;
      case (c)
        0: check("l3_gnt", 32'(gnt3), 32'h2);
        1: check("l3_gnt", 32'(gnt3), 32'h1);
        2: check("l3_gnt", 32'(gnt3), 32'h2);
        default: ;
      endcase
      case (c)
        3: begin check("l3_rv", 32'(rv3), 32'h2); check("l3_rdata", rd3, 32'hBEEF_00A1); end
        4: begin check("l3_rv", 32'(rv3), 32'h1); check("l3_rdata", rd3, 32'hBEEF_00A2); end
        5: begin check("l3_rv", 32'(rv3), 32'h2); check("l3_rdata", rd3, 32'hBEEF_00A3); end
        default: begin check("l3_rv", 32'(rv3), 32'h0); check("l3_rdata", rd3, 32'h0); end
      endcase
    end

    // Latency 2: reset right after three grants discards their returns.
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      req = 4'b1111;
      #1;
      check("l2_gnt", 32'(gnt2), (c == 0) ? 32'h4 : (c == 1) ? 32'h8 : 32'h1);
    end
    next_cycle();
    rst = 1'b1;
    #1;
    check("l2_rst_rv",    32'(rv2),  32'h0);
    check("l2_rst_rdata", rd2,       32'h0);
    check("l2_rst_gnt",   32'(gnt2), 32'h0);
    check("l2_rst_en",    32'(en2),  32'h0);
    check("l2_rst_baddr", 32'(ba2),  32'h0);
    check("l2_rst_ov",    32'(ov2),  32'h0);
    check("l2_rst_oid",   32'(oid2), 32'h0);
    for (int c = 0; c < 2; c++) begin
      next_cycle();
      rst = 1'b0;
      req = 4'b0000;
      #1;
      check("l2_post_rv", 32'(rv2), 32'h0);
    end
    next_cycle();
    req = 4'b1111;
    #1;
    check("l2_ptr_reset", 32'(gnt2), 32'h1);
    next_cycle();
    req = 4'b0000;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
